// File: rtl/convertidor_binario_bcd_secuencial.sv
// Iterative multi-channel binary-to-BCD converter (shift-and-add-3, one shift per clock).
// Ports:
//   clk        - system clock, rising edge
//   reset      - synchronous active-high reset
//   datos      - packed channel inputs, channel c at [c*ANCHO +: ANCHO]
//   seleccion  - channel index, sampled when a start is accepted
//   inicio     - start request, accepted only while idle
//   ocupado    - conversion in progress
//   valido     - one-cycle pulse marking the result cycle
//   bcd        - result digits, digit d (0 = units) at [4*d +: 4]
//   desborde   - converted value did not fit in DIGITOS digits
module convertidor_binario_bcd_secuencial #(
    parameter  int unsigned ANCHO   = 10,
    parameter  int unsigned DIGITOS = 4,
    parameter  int unsigned CANALES = 2,
    localparam int unsigned SEL_W   = (CANALES > 1) ? $clog2(CANALES) : 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [CANALES*ANCHO-1:0]   datos,
    input  logic [SEL_W-1:0]           seleccion,
    input  logic                       inicio,
    output logic                       ocupado,
    output logic                       valido,
    output logic [4*DIGITOS-1:0]       bcd,
    output logic                       desborde
);

    localparam int unsigned BCD_W = 4 * DIGITOS;
    localparam int unsigned SR_W  = BCD_W + ANCHO;
    localparam int unsigned CNT_W = $clog2(ANCHO + 1);

    typedef enum logic [1:0] {
        REPOSO   = 2'd0,
        DESPLAZA = 2'd1,
        FIN      = 2'd2
    } estado_t;

    estado_t           estado_q, estado_d;
    logic [SR_W-1:0]   sr_q, sr_d;
    logic              pegado_q, pegado_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ocupado_q, ocupado_d;
    logic              valido_q, valido_d;
    logic [BCD_W-1:0]  bcd_q, bcd_d;
    logic              desborde_q, desborde_d;

    logic [ANCHO-1:0]  dato_sel;
    logic [SR_W-1:0]   ajuste;

    // Channel mux; an out-of-range index falls back to channel 0.
    always_comb begin
        dato_sel = datos[ANCHO-1:0];
        for (int unsigned c = 0; c < CANALES; c++) begin
            if (32'(seleccion) == c) begin
                dato_sel = datos[c*ANCHO +: ANCHO];
            end
        end
    end

    // Add-3 correction of every BCD digit that is 5 or more, ahead of the shift.
    always_comb begin
        ajuste = sr_q;
        for (int unsigned d = 0; d < DIGITOS; d++) begin
            if (sr_q[ANCHO + 4*d +: 4] >= 4'd5) begin
                ajuste[ANCHO + 4*d +: 4] = sr_q[ANCHO + 4*d +: 4] + 4'd3;
            end
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            estado_q   <= REPOSO;
            sr_q       <= '0;
            pegado_q   <= 1'b0;
            cnt_q      <= '0;
            ocupado_q  <= 1'b0;
            valido_q   <= 1'b0;
            bcd_q      <= '0;
            desborde_q <= 1'b0;
        end else begin
            estado_q   <= estado_d;
            sr_q       <= sr_d;
            pegado_q   <= pegado_d;
            cnt_q      <= cnt_d;
            ocupado_q  <= ocupado_d;
            valido_q   <= valido_d;
            bcd_q      <= bcd_d;
            desborde_q <= desborde_d;
        end
    end

    // Next-state and datapath logic.
    always_comb begin
        estado_d   = estado_q;
        sr_d       = sr_q;
        pegado_d   = pegado_q;
        cnt_d      = cnt_q;
        bcd_d      = bcd_q;
        desborde_d = desborde_q;

        case (estado_q)
            REPOSO: begin
                if (inicio) begin
                    sr_d     = {BCD_W'(0), dato_sel};
                    pegado_d = 1'b0;
                    cnt_d    = CNT_W'(ANCHO);
                    estado_d = DESPLAZA;
                end
            end
            DESPLAZA: begin
                sr_d     = {ajuste[SR_W-2:0], 1'b0};
                // Any bit leaving the top digit means the value needs more digits.
                pegado_d = pegado_q | ajuste[SR_W-1];
                cnt_d    = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    estado_d = FIN;
                end
            end
            FIN: begin
                bcd_d      = sr_q[SR_W-1 -: BCD_W];
                desborde_d = pegado_q;
                estado_d   = REPOSO;
            end
            default: begin
                estado_d = REPOSO;
            end
        endcase

        // Status flags follow the state being entered, so they come straight from flops.
        ocupado_d = (estado_d == DESPLAZA);
        valido_d  = (estado_d == FIN);
    end

    assign ocupado  = ocupado_q;
    assign valido   = valido_q;
    assign bcd      = bcd_q;
    assign desborde = desborde_q;

endmodule

// File: tb/tb_convertidor_binario_bcd_secuencial.sv
module tb_convertidor_binario_bcd_secuencial;

    localparam int unsigned AN = 10;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: default parameters
    logic              rst_a;
    logic [2*AN-1:0]   datos_a;
    logic              sel_a;
    logic              ini_a;
    logic              ocu_a, val_a, des_a;
    logic [15:0]       bcd_a;

    // Instance B: three digits, one channel
    logic              rst_b;
    logic [AN-1:0]     datos_b;
    logic              sel_b;
    logic              ini_b;
    logic              ocu_b, val_b, des_b;
    logic [11:0]       bcd_b;

    // Instance C: three channels
    logic              rst_c;
    logic [3*AN-1:0]   datos_c;
    logic [1:0]        sel_c;
    logic              ini_c;
    logic              ocu_c, val_c, des_c;
    logic [15:0]       bcd_c;

    convertidor_binario_bcd_secuencial u_a (
        .clk(clk), .reset(rst_a), .datos(datos_a), .seleccion(sel_a), .inicio(ini_a),
        .ocupado(ocu_a), .valido(val_a), .bcd(bcd_a), .desborde(des_a)
    );

    convertidor_binario_bcd_secuencial #(.ANCHO(10), .DIGITOS(3), .CANALES(1)) u_b (
        .clk(clk), .reset(rst_b), .datos(datos_b), .seleccion(sel_b), .inicio(ini_b),
        .ocupado(ocu_b), .valido(val_b), .bcd(bcd_b), .desborde(des_b)
    );

    convertidor_binario_bcd_secuencial #(.ANCHO(10), .DIGITOS(4), .CANALES(3)) u_c (
        .clk(clk), .reset(rst_c), .datos(datos_c), .seleccion(sel_c), .inicio(ini_c),
        .ocupado(ocu_c), .valido(val_c), .bcd(bcd_c), .desborde(des_c)
    );

    int ntests = 0;
    int nfail  = 0;

    logic [15:0] prev_bcd_a;
    logic        prev_des_a;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Decimal digits of v, units first, truncated to dig digits.
    function automatic logic [31:0] ref_bcd(input int unsigned v, input int unsigned dig);
        logic [31:0] r;
        int unsigned x;
        r = '0;
        x = v;
        for (int d = 0; d < int'(dig); d++) begin
            r[4*d +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic ref_des(input int unsigned v, input int unsigned dig);
        int unsigned lim;
        lim = 1;
        for (int d = 0; d < int'(dig); d++) lim = lim * 10;
        return v >= lim;
    endfunction

    // Full-timing conversion on instance A; optional extra inicio pulses and a datos change.
    task automatic run_a(input int unsigned v, input int unsigned ch,
                         input int ia, input int ib, input int chg);
        logic [31:0] eb;
        logic        ed;
        eb = ref_bcd(v, 4);
        ed = ref_des(v, 4);
        datos_a = 20'($urandom);
        datos_a[ch*AN +: AN] = AN'(v);
        sel_a = 1'(ch);
        ini_a = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i <= int'(AN) + 2; i++) begin
            if (i > 0) begin
                @(posedge clk); #1;
            end
            ini_a = (i == ia) || (i == ib);
            if (i == chg) datos_a = 20'($urandom);
            chk("A_ocupado", 32'(ocu_a), 32'(i < int'(AN)));
            chk("A_valido",  32'(val_a), 32'(i == int'(AN)));
            if (i <= int'(AN)) begin
                chk("A_bcd_held", 32'(bcd_a), 32'(prev_bcd_a));
                chk("A_des_held", 32'(des_a), 32'(prev_des_a));
            end else begin
                chk("A_bcd", 32'(bcd_a), eb);
                chk("A_des", 32'(des_a), 32'(ed));
            end
        end
        ini_a = 1'b0;
        prev_bcd_a = eb[15:0];
        prev_des_a = ed;
    endtask

    task automatic run_b(input int unsigned v);
        datos_b = AN'(v);
        sel_b   = 1'b1;
        ini_b   = 1'b1;
        @(posedge clk); #1;
        ini_b = 1'b0;
        chk("B_ocupado", 32'(ocu_b), 32'd1);
        repeat (AN) @(posedge clk);
        #1;
        chk("B_valido", 32'(val_b), 32'd1);
        @(posedge clk); #1;
        chk("B_bcd", 32'(bcd_b), ref_bcd(v, 3));
        chk("B_des", 32'(des_b), 32'(ref_des(v, 3)));
        chk("B_valido_end", 32'(val_b), 32'd0);
    endtask

    task automatic run_c(input int unsigned v, input int unsigned ch, input int unsigned sel);
        datos_c = 30'($urandom);
        datos_c[ch*AN +: AN] = AN'(v);
        sel_c = 2'(sel);
        ini_c = 1'b1;
        @(posedge clk); #1;
        ini_c = 1'b0;
        datos_c = 30'($urandom);
        repeat (AN) @(posedge clk);
        #1;
        chk("C_valido", 32'(val_c), 32'd1);
        @(posedge clk); #1;
        chk("C_bcd", 32'(bcd_c), ref_bcd(v, 4));
        chk("C_des", 32'(des_c), 32'(ref_des(v, 4)));
    endtask

    initial begin
        rst_a = 1'b1; datos_a = '0; sel_a = 1'b0; ini_a = 1'b0;
        rst_b = 1'b1; datos_b = '0; sel_b = 1'b0; ini_b = 1'b0;
        rst_c = 1'b1; datos_c = '0; sel_c = 2'd0; ini_c = 1'b0;
        prev_bcd_a = '0;
        prev_des_a = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("A_rst_ocupado", 32'(ocu_a), 32'd0);
        chk("A_rst_valido",  32'(val_a), 32'd0);
        chk("A_rst_bcd",     32'(bcd_a), 32'd0);
        chk("A_rst_des",     32'(des_a), 32'd0);
        chk("B_rst_bcd",     32'(bcd_b), 32'd0);
        chk("C_rst_bcd",     32'(bcd_c), 32'd0);
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;

        // Directed cases on the default configuration
        run_a(1023, 1, -1, -1, -1);
        run_a(0,    0, -1, -1, -1);
        run_a(999,  0, -1, -1, -1);
        run_a(512,  0,  3, 10,  2);

        // inicio held high: restart in the idle cycle after the result cycle
        datos_a = '0;
        datos_a[AN-1:0] = AN'(77);
        sel_a = 1'b0;
        ini_a = 1'b1;
        @(posedge clk); #1;
        for (int i = 1; i <= int'(AN) + 2; i++) begin
            @(posedge clk); #1;
            chk("A_b2b_valido",  32'(val_a), 32'(i == int'(AN)));
            chk("A_b2b_ocupado", 32'(ocu_a), 32'((i < int'(AN)) || (i == int'(AN) + 2)));
        end
        chk("A_b2b_bcd1", 32'(bcd_a), 32'h0077);
        ini_a = 1'b0;
        repeat (AN) @(posedge clk);
        #1;
        chk("A_b2b_valido2", 32'(val_a), 32'd1);
        @(posedge clk); #1;
        chk("A_b2b_bcd2", 32'(bcd_a), 32'h0077);
        prev_bcd_a = 16'h0077;
        prev_des_a = 1'b0;

        // Reset in the middle of a conversion aborts it
        datos_a = '0;
        datos_a[AN-1:0] = AN'(700);
        sel_a = 1'b0;
        ini_a = 1'b1;
        @(posedge clk); #1;
        ini_a = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_a = 1'b1;
        @(posedge clk); #1;
        rst_a = 1'b0;
        chk("A_abort_ocupado", 32'(ocu_a), 32'd0);
        chk("A_abort_valido",  32'(val_a), 32'd0);
        chk("A_abort_bcd",     32'(bcd_a), 32'd0);
        chk("A_abort_des",     32'(des_a), 32'd0);
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            chk("A_abort_no_valido", 32'(val_a), 32'd0);
            chk("A_abort_idle",      32'(ocu_a), 32'd0);
        end
        prev_bcd_a = '0;
        prev_des_a = 1'b0;
        run_a(700, 0, -1, -1, -1);

        // Random values and channels on the default configuration
        for (int n = 0; n < 100; n++) begin
            run_a($urandom_range(1023), $urandom_range(1), -1, -1, -1);
        end

        // Three-digit overflow boundary
        run_b(1000);
        run_b(999);
        run_b(0);
        run_b(1023);
        for (int n = 0; n < 50; n++) begin
            run_b($urandom_range(1023));
        end

        // Out-of-range selection falls back to channel 0, then full sweep on every channel
        run_c(42, 0, 3);
        for (int unsigned ch = 0; ch < 3; ch++) begin
            for (int unsigned v = 0; v < 1024; v++) begin
                run_c(v, ch, ch);
            end
        end

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule

// File: doc/convertidor_binario_bcd_secuencial.md
# convertidor_binario_bcd_secuencial

Iterative, multi-channel binary-to-BCD converter using the shift-and-add-3 method, one shift per clock. It generalises our combinational 10-bit/4-digit converter: input width, digit count and number of selectable channels are parameters. A start/busy/valid handshake replaces the unrolled combinational loop, and an overflow flag is added. It sits between the measurement registers (current, frequency, …) and the 7-segment multiplexer, which consumes the registered BCD digits.

## Interface
- ANCHO, 10: binary input width per channel (≥1).
- DIGITOS, 4: number of BCD digits produced (≥1).
- CANALES, 2: number of selectable input channels (≥1).
- SEL_W (localparam): max(1, clog2(CANALES)).

- clk  in  1  system clock; everything is on its rising edge.
- reset  in  1  synchronous, active-high reset.
- datos  in  CANALES*ANCHO  packed channel inputs; channel c occupies bits [c*ANCHO +: ANCHO].
- seleccion  in  SEL_W  channel index; sampled only when a start is accepted.
- inicio  in  1  start request; accepted only in REPOSO.
- ocupado  out  1  conversion in progress.
- valido  out  1  one-cycle pulse when a new result is on bcd/desborde.
- bcd  out  4*DIGITOS  result digits; digit d (d=0 is units) is at [4*d +: 4].
- desborde  out  1  the converted value was ≥ 10^DIGITOS.

## Operation
- Internal state: a shift register of width 4*DIGITOS+ANCHO (binary part at the bottom), a sticky overflow bit, and a down-counter of width clog2(ANCHO+1).
- FSM states: REPOSO, DESPLAZA, FIN.
- In REPOSO with inicio=1:
  - Load the binary part with datos[seleccion]. If seleccion ≥ CANALES, load channel 0.
  - Clear the BCD part and the sticky overflow bit.
  - Set the counter to ANCHO and go to DESPLAZA.
- In DESPLAZA, each cycle:
  - Add 3 to every BCD digit that is ≥5, for all DIGITOS digits at once.
  - Shift the whole register left by 1.
  - OR the bit shifted out of the top digit's MSB into the sticky overflow bit.
  - Decrement the counter. When it reaches 0 after this shift, go to FIN.
- In FIN:
  - Register the BCD part into bcd and the sticky bit into desborde.
  - Assert valido for this one cycle and go to REPOSO.
- On overflow, bcd holds the value mod 10^DIGITOS and desborde=1.
- bcd and desborde hold their last result until the next FIN. datos may change freely after the start is accepted.
- inicio while ocupado=1 or valido=1 is ignored. It is neither queued nor restarted.
- Every output digit is always in the range 0–9.

## Timing
- Reset values: state REPOSO, ocupado=0, valido=0, bcd=0, desborde=0, counter=0.
- Reset has priority over every other event. Reset asserted mid-conversion aborts it: the next cycle is REPOSO with all outputs at their reset values, and no valido is produced.
- Start accepted at edge k: ocupado=1 from after edge k.
- Shifts happen at edges k+1 through k+ANCHO.
- FIN is the state during the cycle after edge k+ANCHO. In that cycle ocupado=0 and valido=1. bcd/desborde take their new values at edge k+ANCHO+1.
- Latency from the start edge to the result edge is ANCHO+1 cycles. Throughput is one conversion per ANCHO+2 cycles.
- inicio held high continuously: a new start is accepted in the REPOSO cycle that follows FIN. That is back-to-back with a one-cycle gap.
- ocupado and valido are never both 1.

## Test plan
- Defaults, channel 1 = 1023, seleccion=1, inicio pulsed -> ocupado for 10 cycles, then valido one cycle later with bcd=16'h1023 and desborde=0; the previous result is held until that edge.
- Defaults, channel 0 = 0, then channel 0 = 999, seleccion=0 -> bcd=16'h0000, then bcd=16'h0999, each with desborde=0 and exactly one valido per start.
- ANCHO=10, DIGITOS=3, input 1000 -> bcd=12'h000, desborde=1. Input 999 -> bcd=12'h999, desborde=0.
- Defaults, start with 512, pulse inicio again at cycles 3 and 10 after the start, and change datos at cycle 2 -> a single valido, bcd=16'h0512, ocupado timing unchanged.
- Defaults, assert reset 5 cycles into a conversion of 700 -> outputs are at their reset values the next cycle and no valido appears. A fresh start with 700 then yields bcd=16'h0700.
- CANALES=3, seleccion=3 with channel 0 = 42 -> bcd=16'h0042. Sweep all 0–1023 on each channel against a reference model -> every case matches.
